bitrev_reorder_pp: RTL

Parametrised, streaming bit-reversal reorder buffer for the FFT output stage. It accepts `LANES` bit-reversed-order samples per beat and emits the same frame in natural order, also `LANES` samples per beat. Two ping-pong banks let one frame be written while the previous one drains. It uses valid/ready handshakes on both sides and has a per-frame bypass mode. It sits between the last FFT butterfly stage and downstream consumers.

---
 rtl/fft_reorder_pkg.sv | 20 ++
 rtl/bitrev_reorder_pp_bank.sv | 46 ++++
 rtl/bitrev_reorder_pp.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fft_reorder_pkg.sv
// Shared types and helpers for the FFT output bit-reversal reorder buffer.
package fft_reorder_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  // Reverse the low 'bits' bits of v.
  function automatic int bitrev(input int v, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) begin
      if (((v >> i) & 1) != 0) r = r | (1 << (bits - 1 - i));
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_reorder_pp_bank.sv
// One N_FFT-deep reorder bank: LANES scattered write ports, LANES linear read ports.
module reorder_bank
  import fft_reorder_pkg::*;
#(
  parameter int unsigned N_FFT = 512,
  parameter int unsigned LANES = 16,
  parameter int unsigned DW    = 13,
  localparam int unsigned AW    = $clog2(N_FFT),
  localparam int unsigned BEATS = N_FFT / LANES,
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [CW-1:0]            wcnt_i,
  input  logic                     mode_i,
  input  logic [LANES-1:0][DW-1:0] wdata_i,
  input  logic [CW-1:0]            rcnt_i,
  output logic [LANES-1:0][DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [N_FFT];
  logic [AW-1:0] waddr [LANES];

  // Bypass stores in arrival order; normal mode scatters to the bit-reversed index.
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      waddr[l] = mode_i ? AW'(int'(wcnt_i) * int'(LANES) + l)
                        : AW'(bitrev(int'(wcnt_i) * int'(LANES) + l, int'(AW)));
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int l = 0; l < int'(LANES); l++) begin
        mem_q[waddr[l]] <= wdata_i[l];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      rdata_o[l] = mem_q[AW'(int'(rcnt_i) * int'(LANES) + l)];
    end
  end

endmodule

// File: rtl/bitrev_reorder_pp.sv
// Ping-pong bit-reversal reorder buffer: bit-reversed frames in, natural-order frames out.
module bitrev_reorder_pp
  import fft_reorder_pkg::*;
#(
  parameter int unsigned N_FFT = 512,
  parameter int unsigned LANES = 16,
  parameter int unsigned DW    = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES-1:0][DW-1:0] din,
  input  logic                     di_en,
  output logic                     di_rdy,
  input  logic                     bypass,
  output logic [LANES-1:0][DW-1:0] dout,
  output logic                     do_en,
  input  logic                     do_rdy,
  output logic                     do_sof,
  output logic                     do_eof
);

  localparam int unsigned BEATS = N_FFT / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef logic signed [DW-1:0] sample_t;

  bank_state_t   st_q [2];
  bank_state_t   st_d [2];
  logic [1:0]    mode_q, mode_d;
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          wr_fire, rd_fire;
  logic [1:0]    bank_we, bank_mode;

  logic [LANES-1:0][DW-1:0] rdata [2];
  sample_t [LANES-1:0]      rd_sel;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank #(
      .N_FFT (N_FFT),
      .LANES (LANES),
      .DW    (DW)
    ) u_bank (
      .clk     (clk),
      .we_i    (bank_we[b]),
      .wcnt_i  (wcnt_q),
      .mode_i  (bank_mode[b]),
      .wdata_i (din),
      .rcnt_i  (rcnt_q),
      .rdata_o (rdata[b])
    );
  end

  // Handshakes, frame flags and per-bank write controls.
  always_comb begin
    di_rdy  = (st_q[wbank_q] != FULL);
    do_en   = (st_q[rbank_q] == FULL);
    wr_fire = di_en & di_rdy;
    rd_fire = do_en & do_rdy;
    do_sof  = do_en & (rcnt_q == '0);
    do_eof  = do_en & (rcnt_q == LAST_BEAT);
    for (int b = 0; b < 2; b++) begin
      bank_we[b]   = wr_fire & (wbank_q == 1'(b));
      // The first beat writes before the mode bit is captured, so use bypass directly.
      bank_mode[b] = (wcnt_q == '0) ? bypass : mode_q[b];
    end
    rd_sel = rbank_q ? rdata[1] : rdata[0];
    dout   = do_en ? rd_sel : '0;
  end

  // Bank state machines and write/read counters.
  always_comb begin
    st_d    = st_q;
    mode_d  = mode_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    if (wr_fire) begin
      if (wcnt_q == '0) begin
        st_d[wbank_q]   = FILLING;
        mode_d[wbank_q] = bypass;
      end
      if (wcnt_q == LAST_BEAT) begin
        st_d[wbank_q] = FULL;
        wbank_d       = ~wbank_q;
        wcnt_d        = '0;
      end else begin
        wcnt_d = wcnt_q + CW'(1);
      end
    end
    if (rd_fire) begin
      if (rcnt_q == LAST_BEAT) begin
        st_d[rbank_q] = EMPTY;
        rbank_d       = ~rbank_q;
        rcnt_d        = '0;
      end else begin
        rcnt_d = rcnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      mode_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      st_q    <= st_d;
      mode_q  <= mode_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

endmodule
